// File: rtl/grom_io_pkg.sv
// Shared definitions for the grom8 I/O stage: port addresses, status bit layout
// and the UART transmitter state encoding.
package grom_io_pkg;

  localparam logic [1:0] IO_PORT_LED    = 2'd0;
  localparam logic [1:0] IO_PORT_UART   = 2'd1;
  localparam logic [1:0] IO_PORT_STATUS = 2'd2;
  localparam logic [1:0] IO_PORT_RSVD   = 2'd3;

  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_OCC_LSB = 4;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Occupancy field is only four bits wide; a full 16-entry FIFO shows 15.
  function automatic logic [3:0] occ_sat(input logic [4:0] n);
    return (n > 5'd15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/grom_io_if.sv
// CPU-side I/O bus as seen by grom_io; data_in carries CPU write data,
// data_out carries registered read data back to the CPU.
interface grom_io_if;
  logic [11:0] addr;
  logic [7:0]  data_in;
  logic        we;
  logic        ioreq;
  logic [7:0]  data_out;

  modport master (output addr, data_in, we, ioreq, input data_out);
  modport slave  (input addr, data_in, we, ioreq, output data_out);
endinterface

// File: rtl/grom_uart_tx.sv
// 8N1 UART transmitter: accepts a byte when idle, then sends start, eight data
// bits LSB-first and a stop bit, each CLK_DIV clock cycles long.
module grom_uart_tx
  import grom_io_pkg::*;
#(
  parameter logic [15:0] CLK_DIV = 16'd104
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       txd
);

  tx_state_e   state, state_n;
  logic [15:0] div, div_n;
  logic [2:0]  bitcnt, bitcnt_n;
  logic [7:0]  shreg, shreg_n;
  logic        txd_n;
  logic        div_last;

  assign div_last = (div == CLK_DIV - 16'd1);
  assign tx_busy  = (state != TX_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= TX_IDLE;
      div    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      txd    <= 1'b1;
    end else begin
      state  <= state_n;
      div    <= div_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      txd    <= txd_n;
    end
  end

  // txd is registered, so each branch sets the line level for the coming bit.
  always_comb begin
    state_n  = state;
    div_n    = div;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    txd_n    = txd;
    tx_ready = 1'b0;
    unique case (state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        txd_n    = 1'b1;
        if (tx_valid) begin
          shreg_n = tx_byte;
          div_n   = '0;
          txd_n   = 1'b0;
          state_n = TX_START;
        end
      end
      TX_START: begin
        if (div_last) begin
          div_n    = '0;
          bitcnt_n = '0;
          txd_n    = shreg[0];
          state_n  = TX_DATA;
        end else begin
          div_n = div + 16'd1;
        end
      end
      TX_DATA: begin
        if (div_last) begin
          div_n = '0;
          if (bitcnt == 3'd7) begin
            txd_n   = 1'b1;
            state_n = TX_STOP;
          end else begin
            bitcnt_n = bitcnt + 3'd1;
            shreg_n  = shreg >> 1;
            txd_n    = shreg[1];
          end
        end else begin
          div_n = div + 16'd1;
        end
      end
      TX_STOP: begin
        if (div_last) begin
          div_n   = '0;
          state_n = TX_IDLE;
        end else begin
          div_n = div + 16'd1;
        end
      end
      default: state_n = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/grom_io.sv
// grom8 I/O stage: LED port, TX FIFO and UART transmitter on the CPU I/O bus.
// Define GROM_IO_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise one holding register.
module grom_io
  import grom_io_pkg::*;
#(
  parameter logic [15:0] CLK_DIV    = 16'd104,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  grom_io_if.slave   bus,
  output logic       txd,
  output logic [7:0] leds
);

  logic       wq, wq_d, wr_stb;
  logic [1:0] port;
  logic       push_req, push_ok, pop;
  logic       full, empty;
  logic [4:0] count;
  logic [7:0] head;
  logic       ovf;
  logic       tx_ready, tx_busy;
  logic [7:0] status, rd_data;
  logic       unused_addr_bits;

  assign port             = bus.addr[1:0];
  assign unused_addr_bits = ^bus.addr[11:2];

  // Only the first cycle of a held write qualifier performs the write.
  assign wq     = bus.ioreq & bus.we;
  assign wr_stb = wq & ~wq_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) wq_d <= 1'b0;
    else          wq_d <= wq;
  end

  assign pop      = tx_ready & ~empty;
  assign push_req = wr_stb & (port == IO_PORT_UART);
  assign push_ok  = push_req & (~full | pop);

`ifdef GROM_IO_TX_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  assign full  = (count == 5'(FIFO_DEPTH));
  assign empty = (count == 5'd0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      count <= count + 5'(push_ok) - 5'(pop);
    end
  end
`else
  localparam int unsigned unused_fifo_depth = FIFO_DEPTH;

  logic       hold_valid;
  logic [7:0] hold_data;

  assign full  = hold_valid;
  assign empty = ~hold_valid;
  assign head  = hold_data;
  assign count = {4'd0, hold_valid};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (push_ok) begin
      hold_valid <= 1'b1;
      hold_data  <= bus.data_in;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf  <= 1'b0;
      leds <= '0;
    end else begin
      if (push_req && full && !pop)                ovf <= 1'b1;
      else if (wr_stb && port == IO_PORT_STATUS)   ovf <= 1'b0;
      if (wr_stb && port == IO_PORT_LED)           leds <= bus.data_in;
    end
  end

  always_comb begin
    status                      = '0;
    status[ST_FULL]             = full;
    status[ST_EMPTY]            = empty;
    status[ST_BUSY]             = tx_busy;
    status[ST_OVF]              = ovf;
    status[ST_OCC_LSB +: 4]     = occ_sat(count);
  end

  always_comb begin
    rd_data = '0;
    if (bus.ioreq && !bus.we) begin
      unique case (port)
        IO_PORT_LED:    rd_data = leds;
        IO_PORT_STATUS: rd_data = status;
        default:        rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.data_out <= '0;
    else          bus.data_out <= rd_data;
  end

  grom_uart_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_byte  (head),
    .tx_valid (~empty),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .txd      (txd)
  );

endmodule

// File: tb/tb_grom_io.sv
// Self-checking bench for grom_io: directed test-plan steps then random bus
// traffic, all compared against a frame/queue-level reference model.
module tb_grom_io;

  localparam int C     = 4;
  localparam int DEPTH = 4;
`ifdef GROM_IO_TX_FIFO_EN
  localparam int CAP = DEPTH;
`else
  localparam int CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       txd;
  logic [7:0] leds;

  grom_io_if bus ();

  grom_io #(
    .CLK_DIV    (16'(C)),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .txd     (txd),
    .leds    (leds)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: a byte queue, a sticky flag, and the running frame as
  // "byte plus cycles since its start bit began".
  logic [7:0] q[$];
  logic [7:0] m_leds, m_dout, m_byte;
  logic       m_ovf, m_active, m_wq_prev;
  int         m_off;

  function automatic logic [7:0] m_status();
    int n;
    n = q.size();
    return {4'((n > 15) ? 15 : n), m_ovf, m_active, (n == 0), (n == CAP)};
  endfunction

  function automatic logic m_txd();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_off / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_leds = '0; m_dout = '0; m_byte = '0;
    m_ovf = 1'b0; m_active = 1'b0; m_wq_prev = 1'b0; m_off = 0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge: update the model from the inputs currently driven,
  // then compare every output just after the edge.
  task automatic tick();
    logic       wq;
    logic [1:0] a;
    logic [7:0] nd;
    if (reset_n) begin
      wq = bus.ioreq & bus.we;
      a  = bus.addr[1:0];
      nd = '0;
      if (bus.ioreq && !bus.we) begin
        if (a == 2'd0) nd = m_leds;
        else if (a == 2'd2) nd = m_status();
      end
      if (m_active) begin
        m_off++;
        if (m_off == 10*C) m_active = 1'b0;
      end else if (q.size() > 0) begin
        m_byte   = q.pop_front();
        m_active = 1'b1;
        m_off    = 0;
      end
      if (wq && !m_wq_prev) begin
        if (a == 2'd0) m_leds = bus.data_in;
        else if (a == 2'd1) begin
          if (q.size() < CAP) q.push_back(bus.data_in);
          else m_ovf = 1'b1;
        end else if (a == 2'd2) m_ovf = 1'b0;
      end
      m_wq_prev = wq;
      m_dout    = nd;
    end
    @(posedge clk);
    #1;
    check("txd", {7'd0, txd}, {7'd0, m_txd()});
    check("leds", leds, m_leds);
    check("data_out", bus.data_out, m_dout);
  endtask

  task automatic idle_bus();
    bus.ioreq = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.data_in = '0;
  endtask

  task automatic io_write(input logic [1:0] a, input logic [7:0] d);
    bus.ioreq = 1'b1; bus.we = 1'b1; bus.addr = {10'($urandom), a}; bus.data_in = d;
    tick();
    bus.ioreq = 1'b0; bus.we = 1'b0;
    tick();
  endtask

  task automatic io_read(input logic [1:0] a);
    bus.ioreq = 1'b1; bus.we = 1'b0; bus.addr = {10'($urandom), a};
    tick();
    bus.ioreq = 1'b0;
  endtask

  task automatic async_reset();
    #3 reset_n = 1'b0;
    #1;
    check("rst_txd", {7'd0, txd}, 8'h01);
    check("rst_leds", leds, 8'h00);
    check("rst_dout", bus.data_out, 8'h00);
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    idle_bus();
    model_reset();

    // Power-on reset
    #2 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("reset_txd", {7'd0, txd}, 8'h01);
    check("reset_leds", leds, 8'h00);
    io_read(2'd2);
    check("reset_status", bus.data_out, 8'h02);

    // LED write held three cycles with data changing: only the first is taken
    bus.ioreq = 1'b1; bus.we = 1'b1; bus.addr = 12'h000; bus.data_in = 8'hA5;
    tick();
    check("led_write", leds, 8'hA5);
    bus.data_in = 8'h3C;
    tick();
    tick();
    check("led_hold", leds, 8'hA5);
    bus.we = 1'b0;
    tick();
    check("led_read", bus.data_out, 8'hA5);
    idle_bus();
    tick();

    // One UART frame of 0x55
    io_write(2'd1, 8'h55);
    check("start_bit", {7'd0, txd}, 8'h00);
    repeat (10*C + 2) tick();
    io_read(2'd2);
    check("frame_done_status", bus.data_out, 8'h02);

    // Overflow: six rapid pushes
    for (int i = 0; i < 6; i++) io_write(2'd1, 8'(8'h30 + i));
    io_read(2'd2);
`ifdef GROM_IO_TX_FIFO_EN
    check("overflow_status", bus.data_out, 8'h4D);
`else
    check("overflow_status", bus.data_out, 8'h1D);
`endif
    io_write(2'd2, 8'hFF);
    io_read(2'd2);
    check("ovf_cleared", {7'd0, bus.data_out[3]}, 8'h00);

    // Reset in the middle of a data bit
    repeat (8*C) tick();
    while (m_active && (m_off / C) < 3) tick();
    repeat (C/2) tick();
    async_reset();
    tick();
    io_read(2'd2);
    check("post_reset_status", bus.data_out, 8'h02);
    repeat (12*C) tick();

    // Memory cycle with we=1 is ignored
    bus.ioreq = 1'b0; bus.we = 1'b1; bus.addr = 12'h000; bus.data_in = 8'hFF;
    tick();
    tick();
    check("mem_cycle_leds", leds, 8'h00);
    check("mem_cycle_dout", bus.data_out, 8'h00);
    idle_bus();
    tick();

    // Random bus traffic
    for (int i = 0; i < 1500; i++) begin
      bus.ioreq   = ($urandom_range(0, 3) != 0);
      bus.we      = ($urandom_range(0, 2) == 0);
      bus.addr    = 12'($urandom);
      bus.data_in = 8'($urandom);
      tick();
    end
    idle_bus();
    repeat (CAP * 10 * C + 4*C) tick();
    io_read(2'd2);
    check("drained_empty", {7'd0, bus.data_out[1]}, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
